hazard_scoreboard: RTL and testbench

- Per-register pending-write scoreboard for the multi-stage bf8b core.
- Allows decode to issue into exec while writeback is still busy, instead of relying on writeback finishing in one cycle.
- Sits between decode/exec issue and writeback retire:
  - issue side presents the decoded source and destination registers;
  - writeback side retires destination registers;
  - the block gates issue on read-after-write and in-flight-capacity hazards.

---
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard gating issue on RAW and capacity hazards
module hazard_scoreboard #(
  parameter int REG_CNT        = 32,
  parameter int REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int RD_PORTS       = 2,
  parameter int MAX_PER_REG    = 3,
  parameter int MAX_TOTAL      = 4,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter bit RETIRE_BYPASS  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                issue_valid,
  input  logic [RD_PORTS*REG_ADDR_WIDTH-1:0]  issue_rs,
  input  logic [RD_PORTS-1:0]                 issue_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0]           issue_rd,
  input  logic                                issue_rd_we,
  output logic                                issue_ready,
  input  logic                                retire_valid,
  input  logic [REG_ADDR_WIDTH-1:0]           retire_rd,
  input  logic                                flush,
  output logic [REG_CNT-1:0]                  busy_mask,
  output logic [$clog2(MAX_TOTAL+1)-1:0]      inflight,
  output logic [15:0]                         stall_cycles,
  output logic                                retire_err
);

  localparam int CNT_W = $clog2(MAX_PER_REG + 1);
  localparam int TOT_W = $clog2(MAX_TOTAL + 1);

  logic [CNT_W-1:0]          pending [REG_CNT];
  logic [TOT_W-1:0]          total;

  logic                      ret_tracked;
  logic                      ret_hit;
  logic                      ret_miss;
  logic                      rd_tracked;
  logic                      src_hazard;
  logic                      per_reg_full;
  logic                      total_full;
  logic                      issue_fire;
  logic                      stall_evt;
  logic [REG_ADDR_WIDTH-1:0] rs_k;

  function automatic logic is_tracked(input logic [REG_ADDR_WIDTH-1:0] r);
    return !(ZERO_HARDWIRED && (r == '0));
  endfunction

  always_comb begin
    ret_tracked  = retire_valid && is_tracked(retire_rd);
    ret_hit      = ret_tracked && (pending[retire_rd] != '0);
    ret_miss     = ret_tracked && (pending[retire_rd] == '0);
    rd_tracked   = issue_rd_we && is_tracked(issue_rd);

    src_hazard = 1'b0;
    rs_k       = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rs_k = issue_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (issue_rs_used[k] && is_tracked(rs_k) && (pending[rs_k] != '0)) begin
        // The last outstanding write to this source is landing right now.
        if (!(RETIRE_BYPASS && retire_valid && (retire_rd == rs_k) &&
              (pending[rs_k] == CNT_W'(1)))) begin
          src_hazard = 1'b1;
        end
      end
    end

    per_reg_full = rd_tracked && (pending[issue_rd] == CNT_W'(MAX_PER_REG));
    // A same-cycle retire frees one slot of total capacity.
    total_full   = rd_tracked && (total == TOT_W'(MAX_TOTAL)) && !ret_hit;

    issue_ready  = !(src_hazard || per_reg_full || total_full || flush);
    issue_fire   = issue_valid && issue_ready && rd_tracked;
    stall_evt    = issue_valid && !issue_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_CNT; r++) begin
        pending[r] <= '0;
      end
      total        <= '0;
      stall_cycles <= '0;
      retire_err   <= 1'b0;
    end else begin
      if (stall_evt && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end

      if (flush) begin
        for (int r = 0; r < REG_CNT; r++) begin
          pending[r] <= '0;
        end
        total <= '0;
      end else begin
        for (int r = 0; r < REG_CNT; r++) begin
          case ({issue_fire && (issue_rd == REG_ADDR_WIDTH'(r)),
                 ret_hit && (retire_rd == REG_ADDR_WIDTH'(r))})
            2'b10:   pending[r] <= pending[r] + CNT_W'(1);
            2'b01:   pending[r] <= pending[r] - CNT_W'(1);
            default: pending[r] <= pending[r];
          endcase
        end

        case ({issue_fire, ret_hit})
          2'b10:   total <= total + TOT_W'(1);
          2'b01:   total <= total - TOT_W'(1);
          default: total <= total;
        endcase

        if (ret_miss) begin
          retire_err <= 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < REG_CNT; r++) begin : g_busy
    assign busy_mask[r] = (pending[r] != '0);
  end

  assign inflight = total;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed check of hazard_scoreboard against a behavioural model
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [2*AW-1:0] issue_rs;
  logic [1:0]    issue_rs_used;
  logic [AW-1:0] issue_rd;
  logic          issue_rd_we;
  logic          issue_ready;
  logic          retire_valid;
  logic [AW-1:0] retire_rd;
  logic          flush;
  logic [NREG-1:0] busy_mask;
  logic [2:0]    inflight;
  logic [15:0]   stall_cycles;
  logic          retire_err;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
    .busy_mask(busy_mask), .inflight(inflight), .stall_cycles(stall_cycles),
    .retire_err(retire_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: outstanding write count per register, plus totals.
  int pend [NREG];
  int total_m;
  int stall_m;
  bit err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit src_busy(input int r);
    if (r == 0 || pend[r] == 0) return 1'b0;
    if (retire_valid && int'(retire_rd) == r && pend[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    int rd;
    int rr;
    if (flush) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (issue_rs_used[k] && src_busy(int'(issue_rs[k*AW +: AW]))) return 1'b0;
    end
    rd = int'(issue_rd);
    rr = int'(retire_rd);
    if (issue_rd_we && rd != 0) begin
      if (pend[rd] == 3) return 1'b0;
      if (total_m == 4 && !(retire_valid && rr != 0 && pend[rr] > 0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    total_m = 0;
  endtask

  task automatic model_update(input bit rdy);
    bit hit;
    bit miss;
    int rd;
    int rr;
    if (rst) begin
      model_clear();
      stall_m = 0;
      err_m = 1'b0;
      return;
    end
    if (issue_valid && !rdy && stall_m < 65535) stall_m++;
    if (flush) begin
      model_clear();
      return;
    end
    rd = int'(issue_rd);
    rr = int'(retire_rd);
    hit  = retire_valid && rr != 0 && pend[rr] > 0;
    miss = retire_valid && rr != 0 && pend[rr] == 0;
    if (issue_valid && rdy && issue_rd_we && rd != 0) begin
      pend[rd]++;
      total_m++;
    end
    if (hit) begin
      pend[rr]--;
      total_m--;
    end
    if (miss) err_m = 1'b1;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) if (pend[r] > 0) m[r] = 1'b1;
    return m;
  endfunction

  task automatic drive(input bit iv, input int rs0, input int rs1, input logic [1:0] used,
                       input int rd, input bit we, input bit rv, input int rr, input bit fl);
    issue_valid   = iv;
    issue_rs      = {AW'(rs1), AW'(rs0)};
    issue_rs_used = used;
    issue_rd      = AW'(rd);
    issue_rd_we   = we;
    retire_valid  = rv;
    retire_rd     = AW'(rr);
    flush         = fl;
  endtask

  // Inputs are already applied just after a falling edge.
  task automatic step();
    bit rdy;
    #1;
    rdy = model_ready();
    check("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
    model_update(rdy);
    @(negedge clk);
    check("busy_mask", busy_mask, model_mask());
    check("inflight", {29'd0, inflight}, 32'(total_m));
    check("stall_cycles", {16'd0, stall_cycles}, 32'(stall_m));
    check("retire_err", {31'd0, retire_err}, {31'd0, err_m});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_clear();
    stall_m = 0;
    err_m = 1'b0;
    rst = 1'b0;
    check("reset_busy", busy_mask, 32'h0);
    check("reset_ready", {31'd0, issue_ready}, 32'd1);
    check("reset_stall", {16'd0, stall_cycles}, 32'd0);

    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0); step();
    check("tp_busy5", busy_mask, 32'h20);
    check("tp_inflight1", {29'd0, inflight}, 32'd1);
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); step(); step(); step();
    check("tp_stall3", {16'd0, stall_cycles}, 32'd3);
    drive(1, 5, 0, 2'b01, 0, 0, 1, 5, 0); #1;
    check("tp_bypass", {31'd0, issue_ready}, 32'd1);
    step();
    check("tp_bypass_clear", busy_mask, 32'h0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 2'b00, 7, 1, 0, 0, 0); step();
    end
    check("tp_per_reg_cap", {29'd0, inflight}, 32'd3);
    drive(1, 0, 0, 2'b00, 8, 1, 0, 0, 0); step();
    drive(1, 0, 0, 2'b00, 9, 1, 0, 0, 0); step(); step();
    check("tp_total_cap", busy_mask, 32'h180);
    drive(1, 0, 0, 2'b00, 9, 1, 1, 7, 0); step();
    check("tp_total_retire", busy_mask, 32'h380);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1); step();

    drive(1, 0, 0, 2'b11, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 0); step();
    check("tp_zero_err", {31'd0, retire_err}, 32'd0);
    check("tp_zero_inflight", {29'd0, inflight}, 32'd0);
    drive(0, 0, 0, 2'b00, 0, 0, 1, 12, 0); step();
    check("tp_err12", {31'd0, retire_err}, 32'd1);
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0); step();
    drive(1, 0, 0, 2'b00, 3, 1, 1, 3, 0); step();
    check("tp_same_reg", busy_mask, 32'h8);

    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1); step();
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0); step();
    drive(1, 0, 0, 2'b00, 8, 1, 0, 0, 0); step();
    check("tp_pre_flush", busy_mask, 32'h120);
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 1); step();
    check("tp_flush_mask", busy_mask, 32'h0);
    check("tp_flush_inflight", {29'd0, inflight}, 32'd0);
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0); step();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check("tp_rst_stall", {16'd0, stall_cycles}, 32'd0);
    check("tp_rst_err", {31'd0, retire_err}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 9), $urandom_range(0, 9), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9),
            $urandom_range(0, 24) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
